// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: R0-R15, PC, IR, MAR, MDR, Y, 64-bit Z,
// a combinational ALU and IR select-and-encode, sequenced by one-hot strobes.
module data_path (
    input  logic        clock,
    input  logic        clear,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Yin,
    input  logic        Zlowin,
    input  logic        Zhighin,
    input  logic        Rin,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        Zlowout,
    input  logic        Zhighout,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Cout,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        MD_read,
    input  logic        IncPC,
    input  logic        ADD,
    input  logic        SUB,
    input  logic        AND,
    input  logic        OR,
    input  logic        NEG,
    input  logic        NOT,
    input  logic        SHL,
    input  logic        SHR,
    input  logic [31:0] Mdatain,
    output logic [31:0] MAR_q,
    output logic [31:0] bus_q
);

    logic [31:0] pc_reg;
    logic [31:0] ir_reg;
    logic [31:0] mar_reg;
    logic [31:0] mdr_reg;
    logic [31:0] y_reg;
    logic [63:0] z_reg;
    logic [31:0] r_reg [16];

    logic [4:0]  opcode_unused;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [3:0]  reg_idx;
    logic [15:0] reg_sel;
    logic [31:0] c_sext;
    logic [31:0] sel_val;
    logic [31:0] bus;
    logic [31:0] alu_lo;
    logic [31:0] alu_hi;
    logic [31:0] mdr_next;

    // The opcode is decoded by the external control unit, not here.
    assign opcode_unused = ir_reg[31:27];
    assign ra            = ir_reg[26:23];
    assign rb            = ir_reg[22:19];
    assign rc            = ir_reg[18:15];
    assign c_sext        = {{13{ir_reg[18]}}, ir_reg[18:0]};
    assign reg_idx       = (ra & {4{Gra}}) | (rb & {4{Grb}}) | (rc & {4{Grc}});
    assign sel_val       = r_reg[reg_idx];

    for (genvar gi = 0; gi < 16; gi++) begin : g_reg
        assign reg_sel[gi] = (reg_idx == 4'(gi));

        always_ff @(posedge clock or posedge clear) begin
            if (clear) begin
                r_reg[gi] <= '0;
            end else if (Rin && reg_sel[gi]) begin
                r_reg[gi] <= bus;
            end
        end
    end

    // Priority bus mux; control is expected to be one-hot.
    always_comb begin
        bus = '0;
        if (PCout) begin
            bus = pc_reg;
        end else if (MDRout) begin
            bus = mdr_reg;
        end else if (Zlowout) begin
            bus = z_reg[31:0];
        end else if (Zhighout) begin
            bus = z_reg[63:32];
        end else if (Rout) begin
            bus = sel_val;
        end else if (BAout) begin
            // Base-address read treats R0 as a hard zero.
            bus = (reg_idx == 4'd0) ? '0 : sel_val;
        end else if (Cout) begin
            bus = c_sext;
        end
    end

    assign bus_q = bus;
    assign MAR_q = mar_reg;

    always_comb begin
        alu_lo = bus;
        alu_hi = '0;
        if (IncPC) begin
            alu_lo = pc_reg + 32'd1;
        end else if (ADD) begin
            alu_lo = y_reg + bus;
        end else if (SUB) begin
            alu_lo = y_reg - bus;
        end else if (AND) begin
            alu_lo = y_reg & bus;
        end else if (OR) begin
            alu_lo = y_reg | bus;
        end else if (NEG) begin
            alu_lo = -bus;
        end else if (NOT) begin
            alu_lo = ~bus;
        end else if (SHL) begin
            alu_lo = y_reg << bus[4:0];
        end else if (SHR) begin
            alu_lo = y_reg >> bus[4:0];
        end
    end

    assign mdr_next = MD_read ? Mdatain : bus;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            pc_reg  <= '0;
            ir_reg  <= '0;
            mar_reg <= '0;
            mdr_reg <= '0;
            y_reg   <= '0;
            z_reg   <= '0;
        end else begin
            if (PCin)    pc_reg        <= bus;
            if (IRin)    ir_reg        <= bus;
            if (MARin)   mar_reg       <= bus;
            if (MDRin)   mdr_reg       <= mdr_next;
            if (Yin)     y_reg         <= bus;
            if (Zlowin)  z_reg[31:0]   <= alu_lo;
            if (Zhighin) z_reg[63:32]  <= alu_hi;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: stimulus queues expected bus/MAR values,
// a negedge monitor pops and compares them.
module tb_data_path;

    typedef logic [27:0] ctl_t;

    localparam ctl_t K_PCIN     = 28'd1 << 0;
    localparam ctl_t K_IRIN     = 28'd1 << 1;
    localparam ctl_t K_MARIN    = 28'd1 << 2;
    localparam ctl_t K_MDRIN    = 28'd1 << 3;
    localparam ctl_t K_YIN      = 28'd1 << 4;
    localparam ctl_t K_ZLOWIN   = 28'd1 << 5;
    localparam ctl_t K_ZHIGHIN  = 28'd1 << 6;
    localparam ctl_t K_RIN      = 28'd1 << 7;
    localparam ctl_t K_PCOUT    = 28'd1 << 8;
    localparam ctl_t K_MDROUT   = 28'd1 << 9;
    localparam ctl_t K_ZLOWOUT  = 28'd1 << 10;
    localparam ctl_t K_ZHIGHOUT = 28'd1 << 11;
    localparam ctl_t K_ROUT     = 28'd1 << 12;
    localparam ctl_t K_BAOUT    = 28'd1 << 13;
    localparam ctl_t K_COUT     = 28'd1 << 14;
    localparam ctl_t K_GRA      = 28'd1 << 15;
    localparam ctl_t K_GRB      = 28'd1 << 16;
    localparam ctl_t K_GRC      = 28'd1 << 17;
    localparam ctl_t K_MDREAD   = 28'd1 << 18;
    localparam ctl_t K_INCPC    = 28'd1 << 19;
    localparam ctl_t K_ADD      = 28'd1 << 20;
    localparam ctl_t K_SUB      = 28'd1 << 21;
    localparam ctl_t K_AND      = 28'd1 << 22;
    localparam ctl_t K_OR       = 28'd1 << 23;
    localparam ctl_t K_NEG      = 28'd1 << 24;
    localparam ctl_t K_NOT      = 28'd1 << 25;
    localparam ctl_t K_SHL      = 28'd1 << 26;
    localparam ctl_t K_SHR      = 28'd1 << 27;

    logic        clock;
    logic        clear;
    ctl_t        ctl;
    logic        PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, Rin;
    logic        PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Cout;
    logic        Gra, Grb, Grc, MD_read, IncPC;
    logic        ADD, SUB, AND, OR, NEG, NOT, SHL, SHR;
    logic [31:0] Mdatain;
    logic [31:0] MAR_q;
    logic [31:0] bus_q;

    assign {SHR, SHL, NOT, NEG, OR, AND, SUB, ADD, IncPC, MD_read, Grc, Grb, Gra,
            Cout, BAout, Rout, Zhighout, Zlowout, MDRout, PCout,
            Rin, Zhighin, Zlowin, Yin, MDRin, MARin, IRin, PCin} = ctl;

    data_path dut (
        .clock    (clock),
        .clear    (clear),
        .PCin     (PCin),
        .IRin     (IRin),
        .MARin    (MARin),
        .MDRin    (MDRin),
        .Yin      (Yin),
        .Zlowin   (Zlowin),
        .Zhighin  (Zhighin),
        .Rin      (Rin),
        .PCout    (PCout),
        .MDRout   (MDRout),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .Rout     (Rout),
        .BAout    (BAout),
        .Cout     (Cout),
        .Gra      (Gra),
        .Grb      (Grb),
        .Grc      (Grc),
        .MD_read  (MD_read),
        .IncPC    (IncPC),
        .ADD      (ADD),
        .SUB      (SUB),
        .AND      (AND),
        .OR       (OR),
        .NEG      (NEG),
        .NOT      (NOT),
        .SHL      (SHL),
        .SHR      (SHR),
        .Mdatain  (Mdatain),
        .MAR_q    (MAR_q),
        .bus_q    (bus_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] exp_q  [$];
    string       name_q [$];
    bit          kind_q [$];
    logic        chk_req;
    int          checks;
    int          errors;
    logic [31:0] exp_pc;

    // Monitor: one comparison per cycle in which stimulus flagged an observation.
    always @(negedge clock) begin
        if (chk_req) begin
            logic [31:0] act;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: observation with nothing queued");
            end else begin
                act = kind_q[0] ? MAR_q : bus_q;
                if (act !== exp_q[0]) begin
                    errors++;
                    $display("FAIL %s: got %08h expected %08h", name_q[0], act, exp_q[0]);
                end else begin
                    $display("ok   %s: %08h", name_q[0], act);
                end
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
                void'(kind_q.pop_front());
            end
        end
    end

    task automatic step(input ctl_t c);
        ctl = c;
        @(posedge clock);
        #1;
        ctl = '0;
    endtask

    task automatic observe(input ctl_t c, input bit kind, input logic [31:0] e, input string nm);
        ctl = c;
        exp_q.push_back(e);
        name_q.push_back(nm);
        kind_q.push_back(kind);
        chk_req = 1'b1;
        @(posedge clock);
        #1;
        chk_req = 1'b0;
        ctl = '0;
    endtask

    task automatic check_bus(input ctl_t c, input logic [31:0] e, input string nm);
        observe(c, 1'b0, e, nm);
    endtask

    task automatic check_mar(input logic [31:0] e, input string nm);
        observe('0, 1'b1, e, nm);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v;
        step(K_MDREAD | K_MDRIN);
    endtask

    task automatic load_ir(input logic [31:0] v);
        load_mdr(v);
        step(K_MDROUT | K_IRIN);
    endtask

    task automatic write_reg(input logic [3:0] idx, input logic [31:0] v);
        load_ir({5'd0, idx, 23'd0});
        load_mdr(v);
        step(K_MDROUT | K_GRA | K_RIN);
    endtask

    task automatic ld_seq(input logic [31:0] ir, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] mem, input string tag);
        Mdatain = ir;
        check_bus(K_PCOUT | K_MARIN | K_INCPC | K_ZLOWIN, exp_pc, {tag, "_t0_pc"});
        check_bus(K_ZLOWOUT | K_PCIN | K_MDREAD | K_MDRIN, exp_pc + 32'd1, {tag, "_t1_pcinc"});
        exp_pc = exp_pc + 32'd1;
        check_bus(K_MDROUT | K_IRIN, ir, {tag, "_t2_ir"});
        check_bus(K_GRB | K_BAOUT | K_YIN, base, {tag, "_t3_base"});
        check_bus(K_COUT | K_ADD | K_ZLOWIN | K_ZHIGHIN, off, {tag, "_t4_cext"});
        check_bus(K_ZLOWOUT | K_MARIN, base + off, {tag, "_t5_ea"});
        check_mar(base + off, {tag, "_mar"});
        Mdatain = mem;
        step(K_MDREAD | K_MDRIN);
        check_bus(K_MDROUT | K_GRA | K_RIN, mem, {tag, "_t7_data"});
        check_bus(K_GRA | K_ROUT, mem, {tag, "_ra_read"});
    endtask

    ctl_t        alu_op  [10];
    logic [31:0] alu_b   [10];
    logic [31:0] alu_exp [10];

    initial begin
        checks  = 0;
        errors  = 0;
        chk_req = 1'b0;
        ctl     = '0;
        Mdatain = '0;
        exp_pc  = '0;
        clear   = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;

        // Load nonzero state, then an asynchronous clear between edges.
        write_reg(4'd5, 32'h5555_5555);
        check_bus(K_GRA | K_ROUT, 32'h5555_5555, "pre_r5");
        load_mdr(32'h0000_0100);
        step(K_MDROUT | K_PCIN);
        step(K_MDROUT | K_ZLOWIN);
        step(K_MDROUT | K_MARIN);
        check_mar(32'h0000_0100, "pre_mar");
        #2;
        clear = 1'b1;
        exp_q.push_back(32'h0);
        name_q.push_back("rst_mar_async");
        kind_q.push_back(1'b1);
        chk_req = 1'b1;
        @(negedge clock);
        #1;
        chk_req = 1'b0;
        clear   = 1'b0;
        @(posedge clock);
        #1;
        check_bus(K_PCOUT, 32'h0, "rst_pc");
        check_bus(K_ZLOWOUT, 32'h0, "rst_zlow");
        check_bus(K_ZHIGHOUT, 32'h0, "rst_zhigh");
        check_bus(K_MDROUT, 32'h0, "rst_mdr");
        load_ir({5'd0, 4'd5, 23'd0});
        check_bus(K_GRA | K_ROUT, 32'h0, "rst_r5");

        // Fetch steps alone from a clean state.
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear   = 1'b0;
        exp_pc  = '0;
        Mdatain = 32'h0090_0055;
        check_bus(K_PCOUT | K_MARIN | K_INCPC | K_ZLOWIN, 32'h0, "fetch_t0");
        check_bus(K_ZLOWOUT | K_PCIN | K_MDREAD | K_MDRIN, 32'h1, "fetch_t1");
        exp_pc = 32'h1;
        check_mar(32'h0, "fetch_mar");
        check_bus(K_PCOUT, 32'h1, "fetch_pc");
        check_bus(K_MDROUT, 32'h0090_0055, "fetch_mdr");
        check_bus(K_PCOUT | K_MDROUT, 32'h1, "prio_pc_over_mdr");

        // ld R1,0x55(R2)
        write_reg(4'd2, 32'h0000_0010);
        ld_seq(32'h0090_0055, 32'h10, 32'h55, 32'hDEAD_BEEF, "ld_r1");
        step(K_GRA | K_ROUT | K_RIN);
        check_bus(K_GRA | K_ROUT, 32'hDEAD_BEEF, "rmw_r1_hold");
        check_bus(K_ZHIGHOUT, 32'h0, "ld_zhigh");

        // ld R3,0x7(R0): base reads as zero even though R0 holds data
        write_reg(4'd0, 32'h0000_1234);
        ld_seq(32'h0180_0007, 32'h0, 32'h7, 32'hCAFE_F00D, "ld_r3");
        check_bus(K_GRB | K_ROUT, 32'h0000_1234, "r0_rout");

        // Negative offset: C=0x7FFFF sign-extends to -1
        ld_seq(32'h0217_FFFF, 32'h10, 32'hFFFF_FFFF, 32'h1357_2468, "ld_neg");

        // ALU operations with Y=0xF0F0000F
        alu_op[0] = K_ADD; alu_b[0] = 32'h0000_0004; alu_exp[0] = 32'hF0F0_0013;
        alu_op[1] = K_SUB; alu_b[1] = 32'h0000_0004; alu_exp[1] = 32'hF0F0_000B;
        alu_op[2] = K_SUB; alu_b[2] = 32'h0F0F_0010; alu_exp[2] = 32'hE1E0_FFFF;
        alu_op[3] = K_AND; alu_b[3] = 32'h0000_0004; alu_exp[3] = 32'h0000_0004;
        alu_op[4] = K_OR;  alu_b[4] = 32'h0000_0004; alu_exp[4] = 32'hF0F0_000F;
        alu_op[5] = K_NEG; alu_b[5] = 32'h0000_0004; alu_exp[5] = 32'hFFFF_FFFC;
        alu_op[6] = K_NOT; alu_b[6] = 32'h0000_0004; alu_exp[6] = 32'hFFFF_FFFB;
        alu_op[7] = K_SHL; alu_b[7] = 32'h0000_0024; alu_exp[7] = 32'h0F00_00F0;
        alu_op[8] = K_SHR; alu_b[8] = 32'h0000_0004; alu_exp[8] = 32'h0F0F_0000;
        alu_op[9] = '0;    alu_b[9] = 32'h1122_3344; alu_exp[9] = 32'h1122_3344;
        load_mdr(32'hF0F0_000F);
        step(K_MDROUT | K_YIN);
        for (int i = 0; i < 10; i++) begin
            load_mdr(alu_b[i]);
            step(K_MDROUT | alu_op[i] | K_ZLOWIN);
            check_bus(K_ZLOWOUT, alu_exp[i], $sformatf("alu_%0d", i));
        end

        // Z low only: 0xFFFFFFFF + 1 wraps to 0, Z high untouched
        load_mdr(32'hFFFF_FFFF);
        step(K_MDROUT | K_YIN);
        load_mdr(32'h0000_0001);
        step(K_MDROUT | K_ADD | K_ZLOWIN);
        check_bus(K_ZLOWOUT, 32'h0, "zlow_wrap");
        check_bus(K_ZHIGHOUT, 32'h0, "zhigh_unchanged");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clock);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
